// File: rtl/reg_file_cmd_ctrl.sv
// rtl/reg_file_cmd_ctrl.sv - command sequencer between RX byte stream and register file
//
// Parses {WR_CMD, addr, data} write frames and {RD_CMD, addr} read frames from
// the RX byte stream. It drives the register file strobes and forwards read data
// to the TX side.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   RX_P_DATA/VLD   received byte and its one-cycle valid strobe
//   RF_RdData/VLD   register file read data and its valid
//   TX_BUSY         TX side cannot accept a byte
//   RF_WrEn/RdEn    one-cycle register file write/read strobes
//   RF_Address      register file address (holds last latched value)
//   RF_WrData       register file write data (holds last latched value)
//   TX_P_DATA/VLD   byte for transmission and its one-cycle strobe
//   CMD_ERR         one-cycle pulse on unknown opcode or read timeout
module reg_file_cmd_ctrl #(
    parameter int              WIDTH      = 8,
    parameter int              ADDR       = 4,
    parameter logic [WIDTH-1:0] WR_CMD    = 8'hAA,
    parameter logic [WIDTH-1:0] RD_CMD    = 8'hBB,
    parameter int              RD_TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RF_RdData,
    input  logic             RF_RdData_VLD,
    input  logic             TX_BUSY,
    output logic             RF_WrEn,
    output logic             RF_RdEn,
    output logic [ADDR-1:0]  RF_Address,
    output logic [WIDTH-1:0] RF_WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             CMD_ERR
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] WR_EXEC = 3'd3;
    localparam logic [2:0] RD_ADDR = 3'd4;
    localparam logic [2:0] RD_EXEC = 3'd5;
    localparam logic [2:0] RD_WAIT = 3'd6;
    localparam logic [2:0] TX_SEND = 3'd7;

    localparam int              TMO_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    logic [2:0]       state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [WIDTH-1:0] rd_byte;

    // Strobes are raised on the same edge that moves into the EXEC/pulse state,
    // so every output is a flop and the pulse lands one cycle after the
    // triggering input is sampled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            rd_byte    <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            RF_WrEn  <= 1'b0;
            RF_RdEn  <= 1'b0;
            TX_D_VLD <= 1'b0;
            CMD_ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == WR_CMD) begin
                            state <= WR_ADDR;
                        end else if (RX_P_DATA == RD_CMD) begin
                            state <= RD_ADDR;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_Address <= RX_P_DATA[ADDR-1:0];
                        state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrData <= RX_P_DATA;
                        RF_WrEn   <= 1'b1;
                        state     <= WR_EXEC;
                    end
                end
                WR_EXEC: begin
                    state <= IDLE;
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_Address <= RX_P_DATA[ADDR-1:0];
                        RF_RdEn    <= 1'b1;
                        state      <= RD_EXEC;
                    end
                end
                RD_EXEC: begin
                    tmo_cnt <= '0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (RF_RdData_VLD) begin
                        rd_byte <= RF_RdData;
                        // With TX free the byte goes out straight away so a
                        // read costs three cycles after its address byte.
                        if (!TX_BUSY) begin
                            TX_P_DATA <= RF_RdData;
                            TX_D_VLD  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= TX_SEND;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        CMD_ERR <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                TX_SEND: begin
                    if (!TX_BUSY) begin
                        TX_P_DATA <= rd_byte;
                        TX_D_VLD  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb/tb_reg_file_cmd_ctrl.sv - directed self-checking bench for reg_file_cmd_ctrl
module tb_reg_file_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RF_RdData;
    logic       RF_RdData_VLD;
    logic       TX_BUSY;
    logic       RF_WrEn;
    logic       RF_RdEn;
    logic [3:0] RF_Address;
    logic [7:0] RF_WrData;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       CMD_ERR;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    reg_file_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .TX_BUSY       (TX_BUSY),
        .RF_WrEn       (RF_WrEn),
        .RF_RdEn       (RF_RdEn),
        .RF_Address    (RF_Address),
        .RF_WrData     (RF_WrData),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VLD      (TX_D_VLD),
        .CMD_ERR       (CMD_ERR)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte is sampled on the posedge inside this call; returns at the
    // negedge of the following cycle (cycle k+1).
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wren"}, {15'd0, RF_WrEn}, 16'd0);
        check({tag, "_rden"}, {15'd0, RF_RdEn}, 16'd0);
        check({tag, "_addr"}, {12'd0, RF_Address}, 16'd0);
        check({tag, "_wdat"}, {8'd0, RF_WrData}, 16'd0);
        check({tag, "_txd"},  {8'd0, TX_P_DATA}, 16'd0);
        check({tag, "_txv"},  {15'd0, TX_D_VLD}, 16'd0);
        check({tag, "_err"},  {15'd0, CMD_ERR}, 16'd0);
    endtask

    initial begin
        RST           = 1'b0;
        RX_P_DATA     = 8'h00;
        RX_D_VLD      = 1'b0;
        RF_RdData     = 8'h00;
        RF_RdData_VLD = 1'b0;
        TX_BUSY       = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // 1: write AA,05,3C
        send_byte(8'hAA);
        send_byte(8'h05);
        check("t1_wren_early", {15'd0, RF_WrEn}, 16'd0);
        send_byte(8'h3C);
        check("t1_wren", {15'd0, RF_WrEn}, 16'd1);
        check("t1_addr", {12'd0, RF_Address}, 16'h0005);
        check("t1_wdat", {8'd0, RF_WrData}, 16'h003C);
        check("t1_rden", {15'd0, RF_RdEn}, 16'd0);
        @(negedge CLK);
        check("t1_wren_off", {15'd0, RF_WrEn}, 16'd0);
        check("t1_wdat_hold", {8'd0, RF_WrData}, 16'h003C);

        // 2: read BB,02 -> 21, TX free
        send_byte(8'hBB);
        send_byte(8'h02);
        check("t2_rden", {15'd0, RF_RdEn}, 16'd1);
        check("t2_wren", {15'd0, RF_WrEn}, 16'd0);
        check("t2_addr", {12'd0, RF_Address}, 16'h0002);
        @(negedge CLK);
        check("t2_rden_off", {15'd0, RF_RdEn}, 16'd0);
        RF_RdData     = 8'h21;
        RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        check("t2_txv", {15'd0, TX_D_VLD}, 16'd1);
        check("t2_txd", {8'd0, TX_P_DATA}, 16'h0021);
        @(negedge CLK);
        check("t2_txv_off", {15'd0, TX_D_VLD}, 16'd0);
        check("t2_txd_hold", {8'd0, TX_P_DATA}, 16'h0021);

        // 3: bad opcode then write AA,01,FF
        send_byte(8'h55);
        check("t3_err", {15'd0, CMD_ERR}, 16'd1);
        check("t3_wren", {15'd0, RF_WrEn}, 16'd0);
        check("t3_rden", {15'd0, RF_RdEn}, 16'd0);
        @(negedge CLK);
        check("t3_err_off", {15'd0, CMD_ERR}, 16'd0);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'hFF);
        check("t3_wren2", {15'd0, RF_WrEn}, 16'd1);
        check("t3_addr2", {12'd0, RF_Address}, 16'h0001);
        check("t3_wdat2", {8'd0, RF_WrData}, 16'h00FF);

        // 4: read BB,03 with TX busy; stray RX bytes ignored
        TX_BUSY = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h03);
        check("t4_rden", {15'd0, RF_RdEn}, 16'd1);
        @(negedge CLK);
        RF_RdData     = 8'h5A;
        RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t4_txv_busy", {15'd0, TX_D_VLD}, 16'd0);
            check("t4_err_busy", {15'd0, CMD_ERR}, 16'd0);
            RX_D_VLD  = (i == 2) || (i == 4);
            RX_P_DATA = (i == 2) ? 8'hAA : 8'h55;
            @(negedge CLK);
        end
        RX_D_VLD = 1'b0;
        check("t4_txv_pre", {15'd0, TX_D_VLD}, 16'd0);
        TX_BUSY = 1'b0;
        @(negedge CLK);
        check("t4_txv", {15'd0, TX_D_VLD}, 16'd1);
        check("t4_txd", {8'd0, TX_P_DATA}, 16'h005A);
        check("t4_wren", {15'd0, RF_WrEn}, 16'd0);
        @(negedge CLK);
        check("t4_txv_off", {15'd0, TX_D_VLD}, 16'd0);

        // 5: read BB,07 with no read-data valid -> timeout
        send_byte(8'hBB);
        send_byte(8'h07);
        check("t5_rden", {15'd0, RF_RdEn}, 16'd1);
        check("t5_addr", {12'd0, RF_Address}, 16'h0007);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t5_err_wait", {15'd0, CMD_ERR}, 16'd0);
            check("t5_txv_wait", {15'd0, TX_D_VLD}, 16'd0);
        end
        @(negedge CLK);
        check("t5_err", {15'd0, CMD_ERR}, 16'd1);
        check("t5_txv", {15'd0, TX_D_VLD}, 16'd0);
        @(negedge CLK);
        check("t5_err_off", {15'd0, CMD_ERR}, 16'd0);

        // 6: reset mid-frame, then a clean write
        send_byte(8'hAA);
        send_byte(8'h09);
        check("t6_addr_pre", {12'd0, RF_Address}, 16'h0009);
        RST = 1'b0;
        #1;
        check_all_zero("t6_rst");
        @(negedge CLK);
        RST = 1'b1;
        RX_P_DATA = 8'h11;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        check("t6_no_partial", {15'd0, RF_WrEn}, 16'd0);
        check("t6_addr_keep0", {12'd0, RF_Address}, 16'd0);
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(8'h11);
        check("t6_wren", {15'd0, RF_WrEn}, 16'd1);
        check("t6_addr", {12'd0, RF_Address}, 16'h0009);
        check("t6_wdat", {8'd0, RF_WrData}, 16'h0011);
        @(negedge CLK);
        check("t6_wren_off", {15'd0, RF_WrEn}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
